mem_arbiter: RTL

- Sequences the single unified word memory between the core's instruction-fetch port and its load/store port.
- Decodes the console and exit MMIO addresses on the data port; those accesses never reach memory.
- Sits between the RV32I core and a synchronous single-port RAM of MEMORY_LEN 32-bit words.
- Data has priority over fetch; a starvation guard bounds how long fetch can be stalled.

---
 rtl/mem_arbiter_pkg.sv | 13 +
 rtl/mem_arbiter_if.sv | 42 ++++
 rtl/mem_arbiter.sv | 79 +++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_pkg: shared MMIO addresses, RAM owner encoding and word-address helper
package mem_pkg;
    localparam logic [31:0] ADDR_CONSOLE = 32'hFFFF0000;
    localparam logic [31:0] ADDR_EXIT    = 32'hABCD0000;

    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_e;

    // Byte address to word index; callers truncate to the RAM address width,
    // which is what makes addresses wrap modulo the RAM size.
    function automatic logic [31:0] word_index(input logic [31:0] addr);
        return addr >> 2;
    endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_core_if / mem_ram_if: core-side fetch+data bus and RAM-side bus
//   mem_core_if: if_req/if_addr -> if_gnt/if_rvalid/if_rdata (fetch),
//                d_req/d_we/d_be/d_addr/d_wdata -> d_gnt/d_rvalid/d_rdata (data);
//                master = core, slave = arbiter.
//   mem_ram_if:  en/we/be/addr/wdata -> rdata (1-cycle read latency);
//                master = arbiter, slave = RAM.
interface mem_core_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;

    modport master (
        output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata
    );
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata
    );
endinterface

interface mem_ram_if #(parameter int MEMORY_BITS = 10);
    logic                   en;
    logic                   we;
    logic [3:0]             be;
    logic [MEMORY_BITS-1:0] addr;
    logic [31:0]            wdata;
    logic [31:0]            rdata;

    modport master (output en, we, be, addr, wdata, input rdata);
    modport slave  (input en, we, be, addr, wdata, output rdata);
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port word RAM between fetch and load/store, decodes console/exit MMIO
//   clk, rst_n          clock, async active-low reset
//   core (slave)        fetch and data request/grant/response bus
//   ram  (master)       synchronous single-port RAM bus
//   con_valid/con_data  one-cycle console byte strobe
//   exit_valid/exit_code sticky program-exit flag and code
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int MEMORY_LEN   = 1024,
    parameter int MEMORY_BITS  = $clog2(MEMORY_LEN),
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    mem_core_if.slave   core,
    mem_ram_if.master   ram,
    output logic        con_valid,
    output logic [7:0]  con_data,
    output logic        exit_valid,
    output logic [31:0] exit_code
);
    owner_e     owner_q, owner_d;
    logic [3:0] starve_q, starve_d;
    logic       mmio_q, we_q;
    logic       d_con, d_exit, d_mmio, live, starve_hit, d_ram_gnt, con_wr, exit_wr;

    always_comb begin
        d_con      = core.d_addr == ADDR_CONSOLE;
        d_exit     = core.d_addr == ADDR_EXIT;
        d_mmio     = d_con || d_exit;
        // Grants are suppressed while in reset and forever once the program has exited.
        live       = rst_n && !exit_valid;
        starve_hit = core.if_req && starve_q == 4'(STARVE_LIMIT);
        core.d_gnt = live && core.d_req && (d_mmio || !starve_hit);
        d_ram_gnt  = core.d_gnt && !d_mmio;
        // Fetch loses only to a data RAM request that is not being held off by the starve guard.
        core.if_gnt = live && core.if_req && !(core.d_req && !d_mmio && !starve_hit);
        ram.en     = d_ram_gnt || core.if_gnt;
        ram.we     = d_ram_gnt && core.d_we;
        ram.be     = ram.we ? core.d_be : 4'b0000;
        ram.addr   = ram.en ? MEMORY_BITS'(word_index(d_ram_gnt ? core.d_addr : core.if_addr)) : '0;
        ram.wdata  = ram.we ? core.d_wdata : '0;
        con_wr     = core.d_gnt && d_con && core.d_we;
        exit_wr    = core.d_gnt && d_exit && core.d_we;
        owner_d    = d_ram_gnt ? OWN_D : core.if_gnt ? OWN_IF : OWN_NONE;
        starve_d   = (!core.if_req || core.if_gnt) ? 4'd0 :
                     (d_ram_gnt && starve_q != 4'(STARVE_LIMIT)) ? starve_q + 4'd1 : starve_q;
        core.if_rvalid = owner_q == OWN_IF;
        core.if_rdata  = core.if_rvalid ? ram.rdata : '0;
        core.d_rvalid  = owner_q == OWN_D || mmio_q;
        core.d_rdata   = (owner_q == OWN_D && !we_q) ? ram.rdata : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q    <= OWN_NONE;
            starve_q   <= '0;
            mmio_q     <= 1'b0;
            we_q       <= 1'b0;
            con_valid  <= 1'b0;
            con_data   <= '0;
            exit_valid <= 1'b0;
            exit_code  <= '0;
        end else begin
            owner_q   <= owner_d;
            starve_q  <= starve_d;
            mmio_q    <= core.d_gnt && d_mmio;
            we_q      <= core.d_we;
            con_valid <= con_wr;
            if (con_wr) con_data <= core.d_wdata[7:0];
            // exit_wr needs a grant, and grants stop once exit_valid is set, so the code is captured once.
            if (exit_wr) begin
                exit_valid <= 1'b1;
                exit_code  <= core.d_wdata;
            end
        end
    end
endmodule
